// File: rtl/hazard_forward_unit.sv
// Hazard control on the ID/EXE feedback path: operand-forward selects, load-use stall/bubble,
// taken-branch IF/ID flush sequencing and saturating stall/flush counters.
module hazard_forward_unit #(
  parameter int RN_W             = 5,
  parameter int CNT_W            = 16,
  parameter int BRANCH_FLUSH_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RN_W-1:0]  id_rs,
  input  logic [RN_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch_taken,
  input  logic             exe_wreg,
  input  logic             exe_m2reg,
  input  logic [RN_W-1:0]  exe_rn,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [RN_W-1:0]  mem_rn,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             stall,
  output logic             bubble,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic             MULTI_FLUSH = (BRANCH_FLUSH_CYC > 1);
  localparam logic [1:0]       FLUSH_INIT  = (BRANCH_FLUSH_CYC > 1) ? 2'(BRANCH_FLUSH_CYC - 2) : 2'd0;
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t     state;
  logic [1:0] flush_rem;
  logic       lu;

  // A load in EXE cannot forward yet; register 0 is hard-wired and never forwards.
  function automatic logic [1:0] fwd_sel(input logic [RN_W-1:0] r);
    logic [1:0] sel;
    sel = 2'b00;
    if (r != '0) begin
      if (exe_wreg && !exe_m2reg && exe_rn == r)
        sel = 2'b01;
      else if (mem_wreg && mem_rn == r)
        sel = mem_m2reg ? 2'b11 : 2'b10;
    end
    return sel;
  endfunction

  assign lu = exe_wreg && exe_m2reg && (exe_rn != '0) &&
              ((id_use_rs && id_rs == exe_rn) || (id_use_rt && id_rt == exe_rn));

  // Control outputs are Mealy: they respond to ID inputs in the same cycle.
  always_comb begin
    fwda       = 2'b00;
    fwdb       = 2'b00;
    stall      = 1'b0;
    bubble     = 1'b0;
    flush_ifid = 1'b0;
    if (!rst) begin
      fwda = fwd_sel(id_rs);
      fwdb = fwd_sel(id_rt);
      case (state)
        RUN: begin
          if (lu) begin
            stall  = 1'b1;
            bubble = 1'b1;
          end else if (id_branch_taken) begin
            flush_ifid = 1'b1;
          end
        end
        FLUSH:   flush_ifid = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      flush_rem   <= 2'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && stall_count != CNT_MAX)
        stall_count <= stall_count + 1'b1;
      if (flush_ifid && flush_count != CNT_MAX)
        flush_count <= flush_count + 1'b1;
      case (state)
        RUN: begin
          if (!lu && id_branch_taken && MULTI_FLUSH) begin
            state     <= FLUSH;
            flush_rem <= FLUSH_INIT;
          end
        end
        FLUSH: begin
          if (flush_rem == 2'd0)
            state <= RUN;
          else
            flush_rem <= flush_rem - 2'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
